// File: rtl/aes_pkg.sv
// aes_pkg: shared types and helpers for the sequential AES key-schedule engine.
package aes_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;
    localparam logic [7:0] RCON_INIT = 8'h01;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic cfg_ok(input int n, input int nr, input int nk);
        return (n == 32 * nk) && (nr == nk + 6) && (nk == 4 || nk == 6 || nk == 8);
    endfunction
endpackage

// File: rtl/aes_key_expand_seq_if.sv
// aes_key_expand_seq_if: key/start request, status and round-key read bundle.
interface aes_key_expand_seq_if #(parameter int N = 128);
    logic         start;
    logic [N-1:0] key;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    modport master (output start, key, rk_idx, input busy, done, key_valid, round_key);
    modport slave (input start, key, rk_idx, output busy, done, key_valid, round_key);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box byte lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign s = SBOX[a];
endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: one-word-per-cycle AES key expansion into a round-key buffer.
// Optional AES_KEYEXP_ZEROIZE_EN clears the buffer on reset/LOAD and hides keys until valid.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int NR = 10,
    parameter int NK = 4
) (
    input logic clk,
    input logic reset,
    aes_key_expand_seq_if.slave bus
);
    localparam int W = 4 * (NR + 1);
    if (!cfg_ok(N, NR, NK)) begin : g_cfg_err
        $error("aes_key_expand_seq: inconsistent N/NR/NK");
    end
    state_t       st;
    logic [5:0]   i;
    logic [5:0]   imod;
    logic [7:0]   rcon;
    logic [N-1:0] key_r;
    logic [31:0]  w [W];
    logic [31:0]  prev;
    logic [31:0]  sub_in;
    logic [31:0]  sub;
    logic [31:0]  t;
    logic [5:0]   base;
    logic         hide;
    assign imod   = i % 6'(NK);
    assign prev   = w[i - 6'd1];
    assign sub_in = (NK == 8 && imod == 6'd4) ? prev : {prev[23:0], prev[31:24]};
    assign t      = imod == 6'd0 ? sub ^ {rcon, 24'h0} : (NK == 8 && imod == 6'd4) ? sub : prev;
    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .s(sub[8*b +: 8]));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= IDLE;
            i             <= '0;
            rcon          <= RCON_INIT;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.key_valid <= 1'b0;
        end else begin
            case (st)
                IDLE: if (bus.start) begin
                    st       <= LOAD;
                    key_r    <= bus.key;
                    bus.busy <= 1'b1;
                end
                LOAD: begin
                    st            <= GEN;
                    i             <= 6'(NK);
                    rcon          <= RCON_INIT;
                    bus.key_valid <= 1'b0;
                end
                GEN: begin
                    i <= i + 6'd1;
                    if (imod == 6'd0) rcon <= xtime(rcon);
                    if (i == 6'(W - 1)) begin
                        st            <= DONE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.key_valid <= 1'b1;
                    end
                end
                default: begin
                    st       <= IDLE;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
`ifdef AES_KEYEXP_ZEROIZE_EN
        if (reset || st == LOAD)
            for (int j = 0; j < W; j++) w[j] <= '0;
`endif
        if (!reset && st == LOAD)
            for (int j = 0; j < NK; j++) w[j] <= key_r[N-1-32*j -: 32];
        if (!reset && st == GEN)
            w[i] <= w[i - 6'(NK)] ^ t;
    end
    assign base = {bus.rk_idx, 2'b00};
`ifdef AES_KEYEXP_ZEROIZE_EN
    assign hide = bus.rk_idx > 4'(NR) || !bus.key_valid;
`else
    assign hide = bus.rk_idx > 4'(NR);
`endif
    always_ff @(posedge clk) begin
        if (reset) bus.round_key <= '0;
        else bus.round_key <= hide ? '0 : {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: checks 128/192/256-bit engines against a FIPS-197 reference model.
module tb_aes_key_expand_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic         rst_v;
    logic         st [3];
    logic [255:0] key_v;
    logic [3:0]   rk_v;
    logic         busy_o [3];
    logic         done_o [3];
    logic         kv_o [3];
    logic [127:0] rk_o [3];
    int checks = 0;
    int errors = 0;
    logic [7:0]  sb [256];
    logic [31:0] ref_w [3][60];
    aes_key_expand_seq_if #(.N(128)) b128 ();
    aes_key_expand_seq_if #(.N(192)) b192 ();
    aes_key_expand_seq_if #(.N(256)) b256 ();
    aes_key_expand_seq #(.N(128), .NR(10), .NK(4)) u128 (.clk(clk), .reset(rst_v), .bus(b128));
    aes_key_expand_seq #(.N(192), .NR(12), .NK(6)) u192 (.clk(clk), .reset(rst_v), .bus(b192));
    aes_key_expand_seq #(.N(256), .NR(14), .NK(8)) u256 (.clk(clk), .reset(rst_v), .bus(b256));
    assign b128.start = st[0];
    assign b192.start = st[1];
    assign b256.start = st[2];
    assign b128.key = key_v[255:128];
    assign b192.key = key_v[255:64];
    assign b256.key = key_v;
    assign b128.rk_idx = rk_v;
    assign b192.rk_idx = rk_v;
    assign b256.rk_idx = rk_v;
    assign busy_o = '{b128.busy, b192.busy, b256.busy};
    assign done_o = '{b128.done, b192.done, b256.done};
    assign kv_o = '{b128.key_valid, b192.key_valid, b256.key_valid};
    assign rk_o = '{b128.round_key, b192.round_key, b256.round_key};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] p, q, s;
        for (int a = 0; a < 256; a++) begin
            p = 8'h01;
            repeat (254) p = gmul(p, 8'(a));
            q = p;
            s = p;
            for (int r = 0; r < 4; r++) begin
                q = {q[6:0], q[7]};
                s ^= q;
            end
            sb[a] = s ^ 8'h63;
        end
    endtask

    task automatic ref_expand(input int c, input logic [255:0] k);
        int nk = 4 + 2 * c;
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        for (int j = 0; j < nk; j++) ref_w[c][j] = k[255-32*j -: 32];
        for (int j = nk; j < 4 * (nk + 7); j++) begin
            t = ref_w[c][j-1];
            if (j % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && j % nk == 4) t = subw(t);
            ref_w[c][j] = ref_w[c][j-nk] ^ t;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int c, input int idx, output logic [127:0] v);
        rk_v = 4'(idx);
        @(posedge clk);
        #1;
        v = rk_o[c];
    endtask

    task automatic chk_sched(input int c);
        logic [127:0] v;
        for (int idx = 0; idx <= 10 + 2 * c; idx++) begin
            rd(c, idx, v);
            chk($sformatf("rk%0d_c%0d", idx, c), v,
                {ref_w[c][4*idx], ref_w[c][4*idx+1], ref_w[c][4*idx+2], ref_w[c][4*idx+3]});
        end
    endtask

    function automatic logic [255:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One start pulse; optionally a stray start with another key at loop step inj.
    task automatic run(input int c, input logic [255:0] k, input int inj);
        int n = 1;
        key_v = k;
        st[c] = 1'b1;
        @(posedge clk);
        #1;
        st[c] = 1'b0;
        key_v = rnd_key();
        while (!done_o[c] && n < 100) begin
            if (n == 2) begin
                chk($sformatf("busy_gen_c%0d", c), busy_o[c], 1'b1);
                chk($sformatf("kv_clr_c%0d", c), kv_o[c], 1'b0);
            end
            st[c] = (n == inj);
            if (n == inj) key_v = rnd_key();
            @(posedge clk);
            n++;
            #1;
        end
        st[c] = 1'b0;
        chk($sformatf("lat_c%0d", c), 128'(done_o[c] ? n : -1), 128'(42 + 6 * c));
        @(posedge clk);
        #1;
        chk($sformatf("done_pulse_c%0d", c), done_o[c], 1'b0);
        chk($sformatf("kv_set_c%0d", c), kv_o[c], 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] kat, k;
        logic [127:0] v, hold;
        logic ok;
        int n;
        build_sbox();
        rst_v = 1'b1;
        for (int c = 0; c < 3; c++) st[c] = 1'b0;
        key_v = '0;
        rk_v = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rst_busy_c%0d", c), busy_o[c], 1'b0);
            chk($sformatf("rst_done_c%0d", c), done_o[c], 1'b0);
            chk($sformatf("rst_kv_c%0d", c), kv_o[c], 1'b0);
            chk($sformatf("rst_rk_c%0d", c), rk_o[c], '0);
        end
        rst_v = 1'b0;
        kat = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        for (int c = 0; c < 3; c++) begin
            ref_expand(c, kat);
            run(c, kat, -1);
            chk_sched(c);
        end
        rd(0, 1, v);
        chk("kat128_rk1", v, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        rd(0, 10, v);
        chk("kat128_rk10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        rd(1, 12, v);
        chk("kat192_rk12", v, 128'ha4970a331a78dc09c418c271e3a41d5d);
        rd(2, 14, v);
        chk("kat256_rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd(0, 11, v);
        chk("above_nr_c0_11", v, '0);
        rd(0, 15, v);
        chk("above_nr_c0_15", v, '0);
        rd(1, 13, v);
        chk("above_nr_c1_13", v, '0);
        rd(2, 15, v);
        chk("above_nr_c2_15", v, '0);
        rd(0, 10, hold);
        ok = 1'b1;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (rk_o[0] !== hold || kv_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) ok = 1'b0;
        end
        chk("idle_stable", ok, 1'b1);
        for (int c = 0; c < 3; c++)
            repeat (2) begin
                k = rnd_key();
                ref_expand(c, k);
                run(c, k, -1);
                chk_sched(c);
            end
        k = rnd_key();
        ref_expand(0, k);
        run(0, k, 12);
        chk_sched(0);
        k = rnd_key();
        ref_expand(1, k);
        key_v = k;
        st[1] = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!done_o[1] && n < 100);
        chk("held_lat", 128'(done_o[1] ? n : -1), 128'd48);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) chk("held_idle_busy", busy_o[1], 1'b0);
            if (n == 2) begin
                chk("held_restart_busy", busy_o[1], 1'b1);
                st[1] = 1'b0;
            end
        end while (!done_o[1] && n < 100);
        st[1] = 1'b0;
        chk("held_interval", 128'(done_o[1] ? n : -1), 128'd49);
        @(posedge clk);
        #1;
        chk_sched(1);
        key_v = rnd_key();
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("mid_gen_busy", busy_o[0], 1'b1);
        rst_v = 1'b1;
        @(posedge clk);
        #1;
        rst_v = 1'b0;
        chk("rst_gen_busy", busy_o[0], 1'b0);
        chk("rst_gen_kv", kv_o[0], 1'b0);
        chk("rst_gen_done", done_o[0], 1'b0);
        chk("rst_gen_kv_c2", kv_o[2], 1'b0);
        ok = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) ok = 1'b0;
        end
        chk("rst_gen_no_done", ok, 1'b1);
`ifdef AES_KEYEXP_ZEROIZE_EN
        for (int idx = 0; idx < 16; idx++) begin
            rd(0, idx, v);
            chk($sformatf("zeroize_rk%0d", idx), v, '0);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_key_expand_seq.md
# aes_key_expand_seq

Sequential AES key-schedule engine that sits directly upstream of the AES encrypt/decrypt round datapath. It takes a 128/192/256-bit cipher key, generates one 32-bit schedule word per clock into an internal round-key buffer, and serves any round key by index. The round datapath reads round keys from this block instead of expanding the key combinationally.

## Interface
Parameters:
- N, 128: key width in bits (128, 192 or 256).
- NR, 10: number of rounds (10, 12 or 14; must match N).
- NK, 4: key length in 32-bit words (4, 6 or 8; must match N).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request expansion of `key`; sampled only in IDLE.
- key  in  N  cipher key, MSB-first (FIPS-197 byte order); sampled in the start cycle only.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the schedule is complete.
- key_valid  out  1  buffer holds a complete schedule for the last accepted key.
- rk_idx  in  4  round-key index, 0..NR.
- round_key  out  128  registered round key `rk_idx`: words w[4i]..w[4i+3], with w[4i] at the MSBs.

## Operation
- Buffer: W = 4*(NR+1) words (44/52/60).
- States:
  - IDLE: start=1 moves to LOAD. All other inputs are ignored.
  - LOAD: one cycle. Writes key words w[0..NK-1], sets i=NK, sets rcon=0x01, clears key_valid, then moves to GEN.
  - GEN: each cycle writes w[i] = w[i-NK] ^ t, where t = w[i-1], then:
    - if i mod NK == 0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, and rcon <= xtime(rcon).
    - else if NK == 8 and i mod NK == 4: t = SubWord(t).
    - After writing w[W-1], moves to DONE.
  - DONE: one cycle. done=1, key_valid set. Returns to IDLE.
- xtime: shift left by 1, then XOR 0x1B if bit 7 was set; 8-bit result.
- busy=1 in LOAD and GEN.
- start is ignored outside IDLE. It is not queued.
- key may change freely after the start cycle.
- Read port:
  - round_key <= buffer words for rk_idx, every cycle, in any state.
  - rk_idx > NR gives round_key <= 0.
  - Reads during GEN return whatever the buffer currently holds. The consumer must wait for key_valid.

## Timing
- start sampled high in IDLE at edge T: LOAD during cycle T+1, GEN during cycles T+2..T+1+M with M = W-NK (40/46/52), DONE during cycle T+2+M.
- done/key_valid latency from the start edge: 42/48/54 cycles for 128/192/256.
- key_valid rises with done and stays high until the next LOAD or reset.
- round_key latency: 1 cycle from rk_idx.
- Reset values: state IDLE, busy=0, done=0, key_valid=0, round_key=0, i=0, rcon=0x01.
- Reset asserted mid-GEN: the next cycle is IDLE with all outputs at their reset values. The partial schedule is discarded.
- start and reset high together: reset wins.
- start held high continuously: a new expansion begins in the cycle after DONE (IDLE samples it).

## Configuration
- AES_KEYEXP_ZEROIZE_EN
  - Defined:
    - reset and LOAD clear all W buffer words to zero (LOAD then writes the key words).
    - round_key is forced to 0 whenever key_valid=0.
  - Undefined:
    - the buffer has no reset or clear.
    - round_key reflects the raw buffer contents regardless of key_valid.
  - Cycle timing is identical in both builds.

## Structure
- Shared package aes_pkg:
  - FSM state enum (IDLE/LOAD/GEN/DONE).
  - xtime function.
  - Rcon initial constant 8'h01.
  - function checking the N/NR/NK consistency, used by an elaboration-time assertion.
- Sub-module aes_sbox: combinational 8-bit S-box lookup. Four instances form SubWord.
- Top of the block: FSM, word counter, rcon register, buffer, read mux.

## Test plan
- N=128, key 000102030405060708090a0b0c0d0e0f, start 1 cycle -> done exactly 42 cycles after start edge.
  - rk_idx=1 -> d6aa74fdd2af72fadaa678f1d6ab76fe.
  - rk_idx=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- N=192, key 000102…1617 -> done after 48 cycles; rk_idx=12 -> a4970a331a78dc09c418c271e3a41d5d.
- N=256, key 000102…1e1f -> done after 54 cycles; rk_idx=14 -> 24fc79ccbf0979e9371ac23c6d68de36.
- Pulse start again at GEN cycle 10 with a different key -> ignored; schedule and done timing unchanged from the first key.
- Assert reset at GEN cycle 20 -> next cycle busy=0, key_valid=0, done never pulses. With AES_KEYEXP_ZEROIZE_EN, round_key=0 for every rk_idx.
- After a valid schedule, rk_idx=15 (above NR) -> round_key=0 one cycle later. Leave key_valid=1, start=0 for 100 cycles -> outputs stable.
